deskew_registers: RTL and testbench
===================================

Name: deskew_registers

Overview:
- Output-side counterpart of the systolic array's input skew stage.
- Collects the skewed result stream leaving the array, where lane j of a row arrives j cycles after lane 0. Delays each lane so the whole row emerges as one aligned vector.
- Frames a job of cfg_rows rows with out_valid, out_last and a done pulse.
- Sits between the array's bottom/right edge and the result writer. Shares the array's en stall.

Parameters:
- DATA_WIDTH, 16, width of one lane
- N, 4, number of lanes (array dimension)
- CNT_WIDTH, 8, width of row counters and cfg_rows

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- en  in  1  global advance; 0 freezes all datapath, pipe and counter state
- start  in  1  single-cycle pulse; loads cfg_rows and begins a job
- cfg_rows  in  CNT_WIDTH  rows expected in this job; sampled on start
- in_valid  in  1  row-valid aligned to lane 0 of the skewed stream
- packed_din  in  DATA_WIDTH*N  lane j at [j*DATA_WIDTH +: DATA_WIDTH], lane j skewed by j cycles
- packed_dout  out  DATA_WIDTH*N  aligned row, same lane packing
- out_valid  out  1  aligned row present; a beat is consumed when out_valid && en
- out_last  out  1  qualifies out_valid; final row of the job
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse after the last beat is consumed
- err_overrun  out  1  sticky; in_valid seen while no row is expected

Behaviour:
- Reset: all registers, packed_dout, out_valid, out_last, busy, done and err_overrun go to 0. Reset is asynchronous and may occur mid-job; no done is produced for an interrupted job.
- Lane j passes through N-1-j en-gated registers, then a common en-gated output register.
  - Row latency is N cycles from in_valid (lane 0) to out_valid. Lane j latency is N-j cycles from its own arrival.
  - Registers update only when en=1.
- Valid pipe:
  - N-deep en-gated shift register carries {valid, last} per row.
  - An accepted in_valid enters with last = (in_cnt == rows_q-1).
  - out_valid and out_last are the pipe's final stage. They hold value while en=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start with cfg_rows != 0 -> RUN; rows_q=cfg_rows, in_cnt=0, valid pipe cleared, err_overrun cleared.
  - IDLE: start with cfg_rows == 0 -> DONE; err_overrun cleared.
  - RUN: in_valid && en && in_cnt < rows_q: accepted, in_cnt++.
  - RUN: out_valid && out_last && en -> DONE.
  - RUN: start -> restart exactly as from IDLE. In-flight rows are discarded and no done is produced.
  - DONE: done=1 for exactly one cycle, independent of en -> IDLE.
- Overrun: in_valid && en while in IDLE or DONE, or with in_cnt == rows_q:
  - the beat is not inserted into the pipe;
  - err_overrun is set and stays high until the next start.
- start takes effect regardless of en.
- start and in_valid in the same cycle: start wins, and that in_valid is accepted as row 0 of the new job.
- Counters saturate at rows_q and never wrap.
- Lane data outside valid rows is don't-care. packed_dout still follows the delay lines.

Decomposition:
- Shared package/header deskew_pkg:
  - FSM state localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2
  - lane slice macro/function
- One sub-module, deskew_lane #(DATA_WIDTH, DEPTH): en-gated, async-reset delay line. DEPTH=0 is a wire.
  - Instantiated N times with DEPTH=N-1-j.
  - Followed by the shared output register in the parent.

Test Plan:
1. N=4, cfg_rows=3, en=1. Start at t0. Lane j of row r = 16'h0r0j, driven at t0+1+r+j, with in_valid at t0+1+r.
   - Required: out_valid at t0+1+r+4 with packed_dout={0r03,0r02,0r01,0r00}.
   - out_last on r=2; done at the following cycle; busy falls after done.
2. Same stream with en=0 for 3 cycles mid-job:
   - all outputs hold during the stall;
   - each row is emitted exactly once, in order;
   - out_last still lands on row 2.
3. cfg_rows=3 with a 4th in_valid:
   - the beat is dropped;
   - err_overrun=1 and stays high until the next start;
   - outputs match scenario 1.
4. Assert rst_n=0 asynchronously between clock edges mid-job:
   - out_valid, busy and out_last are 0 immediately;
   - no done is produced;
   - a new start runs cleanly.
5. start with cfg_rows=0:
   - done pulses on the next cycle;
   - out_valid never asserts.
6. start again during RUN with one row in flight, cfg_rows=2:
   - the in-flight row is never emitted;
   - two new rows are emitted with out_last on the second;
   - a single done follows.

Source files
------------

// File: rtl/deskew_pkg.sv
// Shared definitions for the output deskew stage.
//   state_t : controller states (idle, running a job, done pulse)
//   beat_t  : per-row qualifier carried alongside the data through the valid pipe
//   lane_lo : low bit index of a lane inside a packed row vector
package deskew_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic valid;
    logic last;
  } beat_t;

  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/deskew_lane.sv
// Enable-gated delay line for one lane of the skewed result stream.
//   clk, rst_n : clock, async active-low reset
//   en         : advance; 0 holds every stage
//   din        : lane input
//   dout_c     : lane output after DEPTH stages (a straight wire when DEPTH is 0)
module deskew_lane #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout_c
);

  if (DEPTH == 0) begin : g_wire
    logic unused_c;
    assign unused_c = ^{clk, rst_n, en};
    assign dout_c   = din;
  end else begin : g_dly
    logic [DATA_WIDTH-1:0] stage_q [DEPTH];

    // Shift register; stage 0 takes the lane input.
    always_ff @(posedge clk or negedge rst_n) begin : p_shift
      if (!rst_n) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else if (en) begin
        stage_q[0] <= din;
        for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign dout_c = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/deskew_registers.sv
// Output deskew stage of the systolic array: realigns the skewed result stream
// (lane j arriving j cycles after lane 0) into whole rows and frames a job.
//   clk, rst_n     : clock, async active-low reset
//   en             : global advance shared with the array
//   start/cfg_rows : begin a job of cfg_rows rows
//   in_valid       : row valid, aligned to lane 0 of packed_din
//   packed_din     : skewed lanes, lane j at [j*DATA_WIDTH +: DATA_WIDTH]
//   packed_dout    : aligned row
//   out_valid/out_last : row present / final row of the job
//   busy, done     : job in progress / one-cycle completion pulse
//   err_overrun    : sticky, a row arrived while none was expected
module deskew_registers
  import deskew_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned N          = 4,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    start,
  input  logic [CNT_WIDTH-1:0]    cfg_rows,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH*N-1:0] packed_din,
  output logic [DATA_WIDTH*N-1:0] packed_dout,
  output logic                    out_valid,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic                    err_overrun
);

  localparam int unsigned BUS_W = DATA_WIDTH * N;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] rows_q, in_cnt_q;
  beat_t [N-1:0]        pipe_q;
  beat_t                beat_c;
  logic                 accept_c, last_c, overrun_c;
  logic [BUS_W-1:0]     aligned_c;

  // Lane j needs N-1-j stages so every lane of a row lines up at the output register.
  for (genvar j = 0; j < N; j++) begin : g_lane
    deskew_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (N - 1 - j)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .din   (packed_din[lane_lo(j, DATA_WIDTH) +: DATA_WIDTH]),
      .dout_c(aligned_c[lane_lo(j, DATA_WIDTH) +: DATA_WIDTH])
    );
  end

  // Next state, row acceptance and overrun detection; start overrides everything.
  always_comb begin : p_next
    state_d   = state_q;
    accept_c  = 1'b0;
    last_c    = 1'b0;
    overrun_c = 1'b0;
    if (start) begin
      state_d  = (cfg_rows != '0) ? S_RUN : S_DONE;
      accept_c = (cfg_rows != '0) && in_valid && en;
      last_c   = (cfg_rows == CNT_WIDTH'(1));
    end else begin
      case (state_q)
        S_RUN:   if (en && out_valid && out_last) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
      if (in_valid && en) begin
        if (state_q == S_RUN && in_cnt_q < rows_q) begin
          accept_c = 1'b1;
          last_c   = (in_cnt_q == rows_q - CNT_WIDTH'(1));
        end else begin
          overrun_c = 1'b1;
        end
      end
    end
    beat_c.valid = accept_c;
    beat_c.last  = accept_c && last_c;
  end

  // Controller state, row counter and the {valid,last} pipe.
  always_ff @(posedge clk or negedge rst_n) begin : p_ctrl
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rows_q      <= '0;
      in_cnt_q    <= '0;
      pipe_q      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != S_IDLE);
      done    <= (state_d == S_DONE);
      if (start) begin
        // Restart discards every in-flight row; a row arriving with start is row 0.
        rows_q      <= cfg_rows;
        in_cnt_q    <= accept_c ? CNT_WIDTH'(1) : '0;
        err_overrun <= 1'b0;
        pipe_q      <= '0;
        pipe_q[0]   <= beat_c;
      end else begin
        if (accept_c)  in_cnt_q    <= in_cnt_q + CNT_WIDTH'(1);
        if (overrun_c) err_overrun <= 1'b1;
        if (en)        pipe_q      <= {pipe_q[N-2:0], beat_c};
      end
    end
  end

  // Common output register closing every lane's delay path.
  always_ff @(posedge clk or negedge rst_n) begin : p_dout
    if (!rst_n)  packed_dout <= '0;
    else if (en) packed_dout <= aligned_c;
  end

  assign out_valid = pipe_q[N-1].valid;
  assign out_last  = pipe_q[N-1].last;

endmodule

// File: tb/tb_deskew_registers.sv
// Self-checking bench for deskew_registers: directed scenarios plus a random run,
// all checked against a queue-based reference model of the realigned stream.
module tb_deskew_registers;

  localparam int unsigned DW = 16;
  localparam int unsigned N  = 4;
  localparam int unsigned CW = 8;
  localparam int unsigned BW = DW * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] cfg_rows = '0;
  logic          in_valid = 1'b0;
  logic [BW-1:0] packed_din = '0;
  logic [BW-1:0] packed_dout;
  logic          out_valid, out_last, busy, done, err_overrun;

  deskew_registers #(.DATA_WIDTH(DW), .N(N), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .start      (start),
    .cfg_rows   (cfg_rows),
    .in_valid   (in_valid),
    .packed_din (packed_din),
    .packed_dout(packed_dout),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int etick = 0;

  // Skew generator: lane values scheduled by en-tick.
  logic [BW-1:0] sched_val [int];
  logic [N-1:0]  sched_msk [int];

  // Reference model: last N sampled inputs, last N row qualifiers, job phase.
  typedef struct packed {
    logic        v;
    logic        l;
    logic [31:0] ep;
  } vent_t;

  vent_t         vq[$];
  logic [BW-1:0] hq[$];
  logic [31:0]   epoch = '0;
  int            phase = 0;  // 0 idle, 1 run, 2 done
  int            m_rows = 0;
  int            m_cnt = 0;
  logic          m_err = 1'b0;

  function automatic void m_reset();
    vent_t z;
    z = '0;
    vq.delete();
    hq.delete();
    for (int i = 0; i < N; i++) begin
      vq.push_back(z);
      hq.push_back('0);
    end
    phase = 0;
    m_err = 1'b0;
    epoch = epoch + 1;
  endfunction

  function automatic void m_update(input logic s, input logic [CW-1:0] cfg, input logic iv,
                                   input logic e, input logic [BW-1:0] d);
    logic  fv, fl, acc, lst;
    vent_t ent;
    fv  = vq[0].v && (vq[0].ep == epoch);
    fl  = fv && vq[0].l;
    acc = 1'b0;
    lst = 1'b0;
    if (s) begin
      epoch  = epoch + 1;
      m_rows = int'(cfg);
      m_cnt  = 0;
      m_err  = 1'b0;
      if (cfg != 0) begin
        phase = 1;
        if (iv && e) begin
          acc   = 1'b1;
          lst   = (cfg == 1);
          m_cnt = 1;
        end
      end else begin
        phase = 2;
      end
    end else begin
      if (iv && e) begin
        if (phase == 1 && m_cnt < m_rows) begin
          acc   = 1'b1;
          lst   = (m_cnt == m_rows - 1);
          m_cnt = m_cnt + 1;
        end else begin
          m_err = 1'b1;
        end
      end
      if (phase == 2) phase = 0;
      else if (phase == 1 && e && fv && fl) phase = 2;
    end
    if (e) begin
      ent.v  = acc;
      ent.l  = lst;
      ent.ep = epoch;
      vq.push_back(ent);
      void'(vq.pop_front());
      hq.push_back(d);
      void'(hq.pop_front());
    end
  endfunction

  // {out_valid, out_last, busy, done, err_overrun}
  function automatic logic [4:0] exp_ctl();
    logic v, l;
    v = vq[0].v && (vq[0].ep == epoch);
    l = v && vq[0].l;
    return {v, l, phase != 0, phase == 2, m_err};
  endfunction

  // Lane j of the output row was sampled j ticks after lane 0.
  function automatic logic [BW-1:0] exp_dout();
    logic [BW-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++) begin
      logic [BW-1:0] h;
      h = hq[j];
      r[j*DW +: DW] = h[j*DW +: DW];
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] row_val(input logic [7:0] tag);
    logic [BW-1:0] r;
    for (int j = 0; j < N; j++) r[j*DW +: DW] = {tag, 8'(j)};
    return r;
  endfunction

  // One clock: schedule a skewed row if iv, drive inputs, advance the model.
  task automatic cyc(input logic s, input logic [CW-1:0] cfg, input logic iv,
                     input logic e, input logic [7:0] tag);
    int            nt;
    logic [BW-1:0] d, v;
    logic [N-1:0]  m;
    nt = etick + 1;
    if (iv) begin
      for (int j = 0; j < N; j++) begin
        if (!sched_val.exists(nt + j)) begin
          sched_val[nt + j] = '0;
          sched_msk[nt + j] = '0;
        end
        v = sched_val[nt + j];
        m = sched_msk[nt + j];
        v[j*DW +: DW] = {tag, 8'(j)};
        m[j] = 1'b1;
        sched_val[nt + j] = v;
        sched_msk[nt + j] = m;
      end
    end
    d = {$urandom, $urandom};
    if (sched_val.exists(nt)) begin
      v = sched_val[nt];
      m = sched_msk[nt];
      for (int j = 0; j < N; j++) if (m[j]) d[j*DW +: DW] = v[j*DW +: DW];
    end
    start = s; cfg_rows = cfg; in_valid = iv; en = e; packed_din = d;
    @(posedge clk);
    m_update(s, cfg, iv, e, d);
    if (e) etick = etick + 1;
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({packed_dout, out_valid, out_last, busy, done, err_overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got ctl=%b dout=%h want all zero",
               {out_valid, out_last, busy, done, err_overrun}, packed_dout);
    end
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic test_basic();
    int rows_seen = 0, dones = 0;
    for (int c = 0; c < 12; c++) begin
      cyc(c == 0, 8'd3, c >= 1 && c <= 3, 1'b1, 8'(c - 1));
      n_cmp++;
      if ({out_valid, out_last, busy, done, err_overrun} !== exp_ctl()) begin
        n_fail++;
        $display("FAIL basic_ctl c=%0d got %b want %b", c, {out_valid, out_last, busy, done, err_overrun}, exp_ctl());
      end
      n_cmp++;
      if (packed_dout !== exp_dout()) begin
        n_fail++;
        $display("FAIL basic_dout c=%0d got %h want %h", c, packed_dout, exp_dout());
      end
      n_cmp++;
      if ({out_valid, done, busy} !== {c >= 4 && c <= 6, c == 7, c <= 7}) begin
        n_fail++;
        $display("FAIL basic_timing c=%0d got v/d/b=%b want %b", c, {out_valid, done, busy},
                 {c >= 4 && c <= 6, c == 7, c <= 7});
      end
      if (out_valid) begin
        n_cmp++;
        if (packed_dout !== row_val(8'(rows_seen)) || out_last !== (rows_seen == 2)) begin
          n_fail++;
          $display("FAIL basic_row r=%0d got %h last=%b want %h last=%b", rows_seen, packed_dout,
                   out_last, row_val(8'(rows_seen)), rows_seen == 2);
        end
        rows_seen++;
      end
      if (done) dones++;
    end
    n_cmp++;
    if (rows_seen != 3 || dones != 1) begin
      n_fail++;
      $display("FAIL basic_count got rows=%0d dones=%0d want 3 1", rows_seen, dones);
    end
  endtask

  task automatic test_stall();
    int rows_seen = 0, dones = 0, sent = 0;
    logic [BW+1:0] prev;
    for (int c = 0; c < 16; c++) begin
      logic e, iv;
      e  = !(c >= 3 && c <= 5);
      iv = (c == 1 || c == 2 || c == 6);
      prev = {packed_dout, out_valid, out_last};
      cyc(c == 0, 8'd3, iv, e, 8'(sent));
      if (iv) sent++;
      n_cmp++;
      if ({out_valid, out_last, busy, done, err_overrun} !== exp_ctl() || packed_dout !== exp_dout()) begin
        n_fail++;
        $display("FAIL stall_model c=%0d got %b/%h want %b/%h", c, {out_valid, out_last, busy, done, err_overrun},
                 packed_dout, exp_ctl(), exp_dout());
      end
      if (!e) begin
        n_cmp++;
        if ({packed_dout, out_valid, out_last} !== prev) begin
          n_fail++;
          $display("FAIL stall_hold c=%0d got %h want %h", c, {packed_dout, out_valid, out_last}, prev);
        end
      end
      if (out_valid && e) begin
        n_cmp++;
        if (packed_dout !== row_val(8'(rows_seen)) || out_last !== (rows_seen == 2)) begin
          n_fail++;
          $display("FAIL stall_row r=%0d got %h last=%b", rows_seen, packed_dout, out_last);
        end
        rows_seen++;
      end
      if (done) dones++;
    end
    n_cmp++;
    if (rows_seen != 3 || dones != 1) begin
      n_fail++;
      $display("FAIL stall_count got rows=%0d dones=%0d want 3 1", rows_seen, dones);
    end
  endtask

  task automatic test_overrun();
    int rows_seen = 0, dones = 0;
    for (int c = 0; c < 12; c++) begin
      cyc(c == 0, 8'd3, c >= 1 && c <= 4, 1'b1, 8'(c - 1));
      n_cmp++;
      if ({out_valid, out_last, busy, done, err_overrun} !== exp_ctl() || packed_dout !== exp_dout()) begin
        n_fail++;
        $display("FAIL overrun_model c=%0d got %b/%h want %b/%h", c, {out_valid, out_last, busy, done, err_overrun},
                 packed_dout, exp_ctl(), exp_dout());
      end
      n_cmp++;
      if (err_overrun !== (c >= 4)) begin
        n_fail++;
        $display("FAIL overrun_flag c=%0d got %b want %b", c, err_overrun, c >= 4);
      end
      if (out_valid) rows_seen++;
      if (done) dones++;
    end
    n_cmp++;
    if (rows_seen != 3 || dones != 1) begin
      n_fail++;
      $display("FAIL overrun_count got rows=%0d dones=%0d want 3 1", rows_seen, dones);
    end
    // start clears the flag; a row arriving with start is row 0 of the new job
    rows_seen = 0; dones = 0;
    for (int c = 0; c < 8; c++) begin
      cyc(c == 0, 8'd1, c == 0, 1'b1, 8'h5A);
      if (c == 0) begin
        n_cmp++;
        if (err_overrun !== 1'b0) begin
          n_fail++;
          $display("FAIL overrun_clear got %b want 0", err_overrun);
        end
      end
      if (out_valid) begin
        n_cmp++;
        if (packed_dout !== row_val(8'h5A) || out_last !== 1'b1) begin
          n_fail++;
          $display("FAIL start_row0 got %h last=%b want %h last=1", packed_dout, out_last, row_val(8'h5A));
        end
        rows_seen++;
      end
      if (done) dones++;
    end
    n_cmp++;
    if (rows_seen != 1 || dones != 1) begin
      n_fail++;
      $display("FAIL start_row0_count got rows=%0d dones=%0d want 1 1", rows_seen, dones);
    end
  endtask

  task automatic test_zero_rows();
    for (int c = 0; c < 6; c++) begin
      cyc(c == 0, 8'd0, 1'b0, 1'b1, 8'h00);
      n_cmp++;
      if ({out_valid, done, busy} !== {1'b0, c == 0, c == 0}) begin
        n_fail++;
        $display("FAIL zero_rows c=%0d got v/d/b=%b want %b", c, {out_valid, done, busy}, {1'b0, c == 0, c == 0});
      end
      n_cmp++;
      if ({out_valid, out_last, busy, done, err_overrun} !== exp_ctl()) begin
        n_fail++;
        $display("FAIL zero_model c=%0d got %b want %b", c, {out_valid, out_last, busy, done, err_overrun}, exp_ctl());
      end
    end
  endtask

  task automatic test_restart();
    int rows_seen = 0, dones = 0;
    for (int c = 0; c < 14; c++) begin
      logic [7:0] tag;
      tag = (c == 1) ? 8'hA0 : 8'(c - 2);
      cyc(c == 0 || c == 2, 8'd2, c >= 1 && c <= 3, 1'b1, tag);
      n_cmp++;
      if ({out_valid, out_last, busy, done, err_overrun} !== exp_ctl() || packed_dout !== exp_dout()) begin
        n_fail++;
        $display("FAIL restart_model c=%0d got %b/%h want %b/%h", c, {out_valid, out_last, busy, done, err_overrun},
                 packed_dout, exp_ctl(), exp_dout());
      end
      if (out_valid) begin
        n_cmp++;
        if (packed_dout !== row_val(8'(rows_seen)) || out_last !== (rows_seen == 1)) begin
          n_fail++;
          $display("FAIL restart_row r=%0d got %h last=%b want %h", rows_seen, packed_dout, out_last,
                   row_val(8'(rows_seen)));
        end
        rows_seen++;
      end
      if (done) dones++;
    end
    n_cmp++;
    if (rows_seen != 2 || dones != 1) begin
      n_fail++;
      $display("FAIL restart_count got rows=%0d dones=%0d want 2 1", rows_seen, dones);
    end
  endtask

  task automatic test_async_reset();
    int rows_seen = 0, dones = 0;
    for (int c = 0; c < 5; c++) cyc(c == 0, 8'd3, c == 1 || c == 2, 1'b1, 8'(c - 1));
    n_cmp++;
    if ({out_valid, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL areset_pre got v/b=%b want 11", {out_valid, busy});
    end
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    n_cmp++;
    if ({out_valid, busy, out_last, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL areset_now got v/b/l/d=%b want 0000", {out_valid, busy, out_last, done});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 14; c++) begin
      cyc(c == 6, 8'd1, c == 6, 1'b1, 8'h3C);
      n_cmp++;
      if ({out_valid, out_last, busy, done, err_overrun} !== exp_ctl() || packed_dout !== exp_dout()) begin
        n_fail++;
        $display("FAIL areset_model c=%0d got %b/%h want %b/%h", c, {out_valid, out_last, busy, done, err_overrun},
                 packed_dout, exp_ctl(), exp_dout());
      end
      if (out_valid) rows_seen++;
      if (done) begin
        dones++;
        n_cmp++;
        if (c < 7) begin
          n_fail++;
          $display("FAIL areset_stray_done c=%0d got 1 want 0", c);
        end
      end
    end
    n_cmp++;
    if (rows_seen != 1 || dones != 1) begin
      n_fail++;
      $display("FAIL areset_count got rows=%0d dones=%0d want 1 1", rows_seen, dones);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      logic s, iv, e;
      logic [CW-1:0] cfg;
      e   = ($urandom_range(0, 9) != 0);
      s   = ($urandom_range(0, 29) == 0);
      iv  = ($urandom_range(0, 2) != 0);
      cfg = CW'($urandom_range(0, 5));
      cyc(s, cfg, iv, e, 8'($urandom));
      n_cmp++;
      if ({out_valid, out_last, busy, done, err_overrun} !== exp_ctl()) begin
        n_fail++;
        $display("FAIL random_ctl c=%0d got %b want %b", c, {out_valid, out_last, busy, done, err_overrun}, exp_ctl());
      end
      n_cmp++;
      if (packed_dout !== exp_dout()) begin
        n_fail++;
        $display("FAIL random_dout c=%0d got %h want %h", c, packed_dout, exp_dout());
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_basic();
    test_stall();
    test_overrun();
    test_zero_rows();
    test_restart();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
